// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared defaults and helpers for the entropy harvester
package trng_pkg;

  localparam int NUM_RO_DEF     = 5;
  localparam int WORD_W_DEF     = 32;
  localparam int DIV_W_DEF      = 16;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int RCT_CUTOFF_DEF = 32;

  // Ceiling log2; callers pass N+1 when they need to hold the value N itself.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/trng_word_fifo.sv
// rtl/trng_word_fifo.sv - first-word fall-through output word buffer
module trng_word_fifo
  import trng_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                flush,
  input  logic                                push,
  input  logic [WORD_W-1:0]                   push_data,
  input  logic                                pop,
  output logic                                head_valid,
  output logic [WORD_W-1:0]                   head_data,
  output logic                                full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fill
);

  localparam int PTR_W  = clog2(FIFO_DEPTH);
  localparam int FILL_W = clog2(FIFO_DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(FIFO_DEPTH);

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FILL_W-1:0] fill_cnt;
  logic              do_pop;
  logic              do_push;

  assign head_valid = (fill_cnt != '0);
  assign full       = (fill_cnt == FILL_MAX);
  assign fill       = fill_cnt;
  // Head is forced to zero when empty so the output is deterministic.
  assign head_data  = head_valid ? mem[rd_ptr] : '0;
  assign do_pop     = pop && head_valid;
  // A pop frees the slot the push lands in, so push-at-full is legal with a pop.
  assign do_push    = push && (!full || do_pop);

  // Storage array; contents are only observed through the valid-gated head.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   fill_cnt <= fill_cnt + FILL_W'(1);
        2'b01:   fill_cnt <= fill_cnt - FILL_W'(1);
        default: fill_cnt <= fill_cnt;
      endcase
    end
  end

endmodule

// File: rtl/trng_harvester.sv
// rtl/trng_harvester.sv - ring-oscillator entropy harvester with health test
module trng_harvester
  import trng_pkg::*;
#(
  parameter int NUM_RO     = NUM_RO_DEF,
  parameter int WORD_W     = WORD_W_DEF,
  parameter int DIV_W      = DIV_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int RCT_CUTOFF = RCT_CUTOFF_DEF
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            ena,
  input  logic [NUM_RO-1:0]               ro_in,
  input  logic [NUM_RO-1:0]               ro_mask,
  input  logic [DIV_W-1:0]                div_cfg,
  input  logic                            debias_en,
  input  logic                            flush,
  input  logic                            health_clr,
  output logic                            word_valid,
  input  logic                            word_ready,
  output logic [WORD_W-1:0]               word_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fill_level,
  output logic                            health_fail
);

  localparam int RUN_W = clog2(RCT_CUTOFF + 1);
  localparam int CNT_W = clog2(WORD_W + 1);
  localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(RCT_CUTOFF);
  localparam logic [CNT_W-1:0] BITS_FULL = CNT_W'(WORD_W);

  logic [NUM_RO-1:0] sync_q1;
  logic [NUM_RO-1:0] sync_q2;
  logic [DIV_W-1:0]  div_cnt;
  logic              strobe;
  logic              raw;
  logic              last_raw;
  logic [RUN_W-1:0]  run_cnt;
  logic [RUN_W-1:0]  run_next;
  logic              fail_now;
  logic              take;
  logic              pair_state;
  logic              pair_bit;
  logic              bit_valid;
  logic              bit_val;
  logic [WORD_W-1:0] asm_word;
  logic [CNT_W-1:0]  asm_cnt;
  logic              asm_full;
  logic              fifo_full;
  logic              pop;
  logic              push;

  // Two-flop synchronisers run continuously so they are settled when ena rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= ro_in;
      sync_q2 <= sync_q1;
    end
  end

  assign strobe = ena && (div_cnt == div_cfg);
  assign raw    = ^(sync_q2 & ro_mask);

  // Sample-rate divider; held at zero while disabled so the phase restarts cleanly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (!ena || strobe) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Next run length; a cleared run of 0 naturally restarts at 1.
  always_comb begin
    run_next = RUN_W'(1);
    if (raw == last_raw) begin
      run_next = (run_cnt == RUN_MAX) ? RUN_MAX : run_cnt + RUN_W'(1);
    end
  end

  // Failure fires only on the transition into the cutoff, not while saturated.
  assign fail_now = strobe && (run_cnt != RUN_MAX) && (run_next == RUN_MAX);

  // Repetition-count test with a sticky failure flag that outranks health_clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt     <= '0;
      last_raw    <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      if (strobe) last_raw <= raw;
      if (fail_now) begin
        run_cnt     <= run_next;
        health_fail <= 1'b1;
      end else if (health_clr) begin
        run_cnt     <= '0;
        health_fail <= 1'b0;
      end else if (strobe) begin
        run_cnt <= run_next;
      end
    end
  end

  assign take = strobe && !health_fail && !fail_now && !flush;

  // Von Neumann: the first of a pair is held, the second decides.
  always_comb begin
    bit_valid = take;
    bit_val   = raw;
    if (debias_en) begin
      bit_valid = take && pair_state && (pair_bit != raw);
      bit_val   = pair_bit;
    end
  end

  // Pair phase toggles per accepted strobe and restarts on any flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pair_state <= 1'b0;
      pair_bit   <= 1'b0;
    end else if (fail_now || flush || !debias_en) begin
      pair_state <= 1'b0;
    end else if (take) begin
      if (!pair_state) pair_bit <= raw;
      pair_state <= ~pair_state;
    end
  end

  assign asm_full = (asm_cnt == BITS_FULL);
  assign pop      = word_valid && word_ready;
  assign push     = asm_full && (!fifo_full || pop) && !flush && !fail_now;

  // Word assembler; a bit arriving on the push cycle starts the next word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      asm_word <= '0;
      asm_cnt  <= '0;
    end else if (fail_now || flush) begin
      asm_word <= '0;
      asm_cnt  <= '0;
    end else if (push) begin
      asm_word <= bit_valid ? WORD_W'(bit_val) : '0;
      asm_cnt  <= bit_valid ? CNT_W'(1) : '0;
    end else if (bit_valid && !asm_full) begin
      asm_word <= {asm_word[WORD_W-2:0], bit_val};
      asm_cnt  <= asm_cnt + CNT_W'(1);
    end
  end

  trng_word_fifo #(
    .WORD_W     (WORD_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush || fail_now),
    .push       (push),
    .push_data  (asm_word),
    .pop        (pop),
    .head_valid (word_valid),
    .head_data  (word_data),
    .full       (fifo_full),
    .fill       (fill_level)
  );

endmodule

// File: tb/tb_trng_harvester.sv
// tb/tb_trng_harvester.sv - scoreboard bench for trng_harvester
module tb_trng_harvester;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ena = 1'b0;
  logic [4:0]  ro_in = '0;
  logic [4:0]  ro_mask = '0;
  logic [15:0] div_cfg = '0;
  logic        debias_en = 1'b0;
  logic        flush = 1'b0;
  logic        health_clr = 1'b0;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic [7:0]  word_data;
  logic [2:0]  fill_level;
  logic        health_fail;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  trng_harvester #(
    .NUM_RO     (5),
    .WORD_W     (8),
    .DIV_W      (16),
    .FIFO_DEPTH (4),
    .RCT_CUTOFF (32)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ena         (ena),
    .ro_in       (ro_in),
    .ro_mask     (ro_mask),
    .div_cfg     (div_cfg),
    .debias_en   (debias_en),
    .flush       (flush),
    .health_clr  (health_clr),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .word_data   (word_data),
    .fill_level  (fill_level),
    .health_fail (health_fail)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Called right after a strobe edge; the bit is stable well before the next strobe.
  task automatic send_bit(input logic b);
    ro_in[0] = b;
    repeat (int'(div_cfg) + 1) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] exp;
    check_val({tag, "_valid"}, word_valid, 1);
    check_val({tag, "_queued"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      check_val({tag, "_data"}, word_data, exp);
    end
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] vn_bits;
    logic [7:0]  fill_words [5];

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_valid", word_valid, 0);
    check_val("rst_data", word_data, 0);
    check_val("rst_fill", fill_level, 0);
    check_val("rst_fail", health_fail, 0);
    reset_n = 1'b1;

    // Word assembly: 1,0,1,1,0,0,1,0 -> 0xB2
    ro_mask = 5'b00001;
    div_cfg = 16'd3;
    ena = 1'b1;
    exp_q.push_back(8'hB2);
    for (int i = 7; i >= 1; i--) send_bit(bit'(8'hB2 >> i));
    check_val("asm_7bits_valid", word_valid, 0);
    send_bit(1'b0);
    check_val("asm_latency_valid", word_valid, 0);
    ena = 1'b0;
    @(negedge clk);
    check_val("asm_fill", fill_level, 1);
    pop_check("asm_b2");
    check_val("asm_fill_after_pop", fill_level, 0);

    // Asynchronous reset mid-cycle with a word buffered and a partial word
    ena = 1'b1;
    send_byte(8'hC3);
    @(negedge clk);
    check_val("arst_pre_valid", word_valid, 1);
    check_val("arst_pre_data", word_data, 8'hC3);
    for (int i = 0; i < 3; i++) send_bit(i[0]);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    ena = 1'b0;
    #1;
    check_val("arst_valid", word_valid, 0);
    check_val("arst_data", word_data, 0);
    check_val("arst_fill", fill_level, 0);
    check_val("arst_fail", health_fail, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check_val("arst_idle_valid", word_valid, 0);
    check_val("arst_idle_fill", fill_level, 0);

    // Debias: pairs 01 11 10 00 10 01 10 10 01 10 -> 0,1,1,0,1,1,0,1 = 0x6D
    vn_bits = 20'b01_11_10_00_10_01_10_10_01_10;
    debias_en = 1'b1;
    ena = 1'b1;
    exp_q.push_back(8'h6D);
    for (int i = 19; i >= 2; i--) send_bit(vn_bits[i]);
    check_val("vn_7bits_valid", word_valid, 0);
    send_bit(vn_bits[1]);
    send_bit(vn_bits[0]);
    ena = 1'b0;
    @(negedge clk);
    pop_check("vn_6d");
    debias_en = 1'b0;

    // Full FIFO: five words with no consumer, then three bits that must be dropped
    fill_words[0] = 8'hA5;
    fill_words[1] = 8'h3C;
    fill_words[2] = 8'hF0;
    fill_words[3] = 8'h96;
    fill_words[4] = 8'h5A;
    ena = 1'b1;
    for (int w = 0; w < 5; w++) begin
      exp_q.push_back(fill_words[w]);
      send_byte(fill_words[w]);
    end
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    ena = 1'b0;
    @(negedge clk);
    check_val("full_fill", fill_level, 4);
    pop_check("full_w0");
    @(negedge clk);
    check_val("full_refill", fill_level, 4);
    for (int w = 1; w < 5; w++) pop_check($sformatf("full_w%0d", w));
    check_val("full_drained", fill_level, 0);

    // Flush during a pop with a half-built word in the assembler
    ena = 1'b1;
    send_byte(8'h11);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    ena = 1'b0;
    flush = 1'b1;
    word_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    word_ready = 1'b0;
    check_val("flush_fill", fill_level, 0);
    check_val("flush_valid", word_valid, 0);
    ena = 1'b1;
    exp_q.push_back(8'h4E);
    send_byte(8'h4E);
    ena = 1'b0;
    @(negedge clk);
    pop_check("flush_next");

    // Repetition-count health test on a stuck-at-zero source, strobe every cycle
    reset_dut();
    ro_mask = '0;
    div_cfg = '0;
    ena = 1'b1;
    repeat (31) @(negedge clk);
    check_val("rct_pre_fail", health_fail, 0);
    check_val("rct_pre_fill", fill_level, 3);
    @(negedge clk);
    check_val("rct_fail", health_fail, 1);
    check_val("rct_fail_valid", word_valid, 0);
    check_val("rct_fail_fill", fill_level, 0);
    health_clr = 1'b1;
    @(negedge clk);
    health_clr = 1'b0;
    check_val("rct_cleared", health_fail, 0);
    repeat (9) @(negedge clk);
    check_val("rct_accept_again", fill_level, 1);
    repeat (22) @(negedge clk);
    check_val("rct_31_after_clr", health_fail, 0);
    @(negedge clk);
    check_val("rct_32_after_clr", health_fail, 1);
    health_clr = 1'b1;
    @(negedge clk);
    health_clr = 1'b0;
    check_val("rct_cleared2", health_fail, 0);
    repeat (31) @(negedge clk);
    health_clr = 1'b1;
    @(negedge clk);
    health_clr = 1'b0;
    check_val("rct_clr_same_cycle", health_fail, 1);
    health_clr = 1'b1;
    @(negedge clk);
    health_clr = 1'b0;
    check_val("rct_cleared3", health_fail, 0);
    ena = 1'b0;

    check_val("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trng_harvester.md
# trng_harvester

Parametrised entropy harvester for the loop-shuffler RNG path. It samples an external bank of NUM_RO free-running ring oscillators through synchronisers and XORs the enabled channels at a programmable sample rate. Optional von Neumann debiasing is applied, bits are packed into WORD_W-bit words, and the words are buffered in a small FIFO with a valid/ready handshake. A repetition-count health test blocks output when the source sticks. The block sits between the oscillator bank and the shuffler's seed consumer.

## Interface
- NUM_RO, 5, number of oscillator inputs
- WORD_W, 32, output word width (≥2)
- DIV_W, 16, sample-divider width
- FIFO_DEPTH, 4, output words buffered (power of 2, ≥2)
- RCT_CUTOFF, 32, repetition-count failure threshold (≥2)

Ports:
- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- ena  in  1  harvesting enable
- ro_in  in  NUM_RO  raw oscillator outputs, asynchronous to clk
- ro_mask  in  NUM_RO  1 = channel included in XOR
- div_cfg  in  DIV_W  sample period minus 1
- debias_en  in  1  von Neumann debiasing on
- flush  in  1  one-cycle pulse; drops partial word, pair state and FIFO
- health_clr  in  1  one-cycle pulse; clears health_fail
- word_valid  out  1  FIFO head valid
- word_ready  in  1  consumer accepts head
- word_data  out  WORD_W  FIFO head
- fill_level  out  $clog2(FIFO_DEPTH+1)  words in FIFO
- health_fail  out  1  sticky repetition-count failure

## Operation
- Every ro_in bit passes through a 2-flop synchroniser. The synchronisers are always running, independent of ena.
- Divider: when ena=1, cnt increments each cycle. When cnt==div_cfg, a strobe fires and cnt returns to 0. div_cfg=0 gives a strobe every cycle. ena=0 holds cnt at 0 and produces no strobes.
- raw = XOR of (sync & ro_mask), sampled on the strobe. If ro_mask=0, raw=0.
- Health (RCT): a run counter runs on every strobe, whether or not the bit is accepted. If raw==last_raw, run increments, saturating at RCT_CUTOFF. Otherwise run=1. When run reaches RCT_CUTOFF, health_fail sets.
- Consequences of a failure, in the same cycle:
  - the FIFO, the assembler and the pair state are flushed
  - bits stop being accepted
  - health_fail remains set until health_clr
- health_clr resets run to 0, so the next strobe starts run at 1.
- Debias off: every strobed raw bit is an accepted bit.
- Debias on: raw bits are paired. The first bit is latched. On the second bit, a≠b accepts a; a==b discards both. The pair state toggles per strobe.
- Assembler: accepted bits shift in at the LSB (word = {word[WORD_W-2:0], bit}) and a bit count is kept. When the count reaches WORD_W, the word is complete.
  - If the FIFO has space (or is being popped in the same cycle), the word is pushed the next cycle and the assembler clears.
  - Otherwise the word is held and further accepted bits are dropped until the push.
- FIFO: first-word fall-through. word_data is meaningful only while word_valid=1. A pop occurs on word_valid & word_ready. Push and pop in the same cycle are legal at any level, including full.
- Priority: reset_n > health failure > flush > normal.
  - A failure and health_clr in the same cycle leave health_fail=1.
  - flush does not clear health_fail.

## Timing
- Reset values: word_valid=0, word_data=0, fill_level=0, health_fail=0. Divider, run counter, pair state and assembler are all 0.
- ro_in to synchronised value: 2 cycles.
- Strobes occur every div_cfg+1 cycles after ena rises. The first strobe is at cycle div_cfg after the rising edge.
- The strobe edge registers the raw bit into the assembler. Completion on strobe edge N gives word_valid=1 and fill_level+1 after edge N+1.
- A pop at edge k decrements fill_level after k; the next head is visible the same cycle.
- A health failure detected on edge k gives health_fail=1, word_valid=0 and fill_level=0 after k.
- An asynchronous reset mid-word discards everything immediately. Outputs take their reset values without waiting for clk.

## Structure
- Package trng_pkg:
  - localparam defaults for NUM_RO, WORD_W, FIFO_DEPTH and RCT_CUTOFF
  - function clog2
- Sub-module trng_word_fifo(WORD_W, FIFO_DEPTH):
  - FWFT circular buffer with pointer wrap
  - flush input
  - fill count
- Top-level contents: synchronisers, divider, XOR/mask, RCT, debias and assembler.

## Test plan
- Reset check: assert reset_n=0 asynchronously mid-cycle. All outputs go to 0 immediately; no word appears after release while ena=0.
- Word assembly: WORD_W=8, div_cfg=3, debias off, ro_mask=5'b00001. Drive ro_in[0] with bits 1,0,1,1,0,0,1,0, one per strobe and settled ≥3 cycles before each strobe. Expect word_data=0xB2, word_valid=1 one cycle after the 8th strobe, fill_level=1.
- Debias: debias_en=1, raw pairs 01,11,10,00,10,01 → accepted bits 0,1,1,0. The 4-bit assembler (WORD_W=4) yields 0x6.
- Health: ro_mask=0, div_cfg=0, RCT_CUTOFF=32. Expect health_fail=1 after the 32nd strobe and word_valid=0. Pulsing health_clr restores acceptance, and health_fail stays 0 until 32 further identical bits.
- Full FIFO: word_ready=0; four words fill the FIFO (fill_level=4). The 5th word is held and extra bits are dropped. Pop once: the held word is pushed next cycle, fill_level stays 4, and FIFO order is preserved.
- Flush during a pop with a half-built word: fill_level=0 next cycle, and the next word contains only post-flush bits.
